// File: rtl/shifter_operand_unit.sv
// Iterative ARM operand-2 / shifter carry-out generator behind a valid/ready handshake.
// Defining SHIFTER_BUSY_CNT_EN adds the busy_cycles output counting cycles spent in SHIFT.
module shifter_operand_unit #(
  parameter int STEP  = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             imm,
  input  logic             reg_shift,
  input  logic [11:0]      shift_operand,
  input  logic             mem_R_en,
  input  logic             mem_W_en,
  input  logic [31:0]      val_rm,
  input  logic [31:0]      val_rs,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      val2,
  output logic             carry_out
`ifdef SHIFTER_BUSY_CNT_EN
  ,
  output logic [CNT_W-1:0] busy_cycles
`endif
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [1:0] SH_LSL = 2'd0;
  localparam logic [1:0] SH_LSR = 2'd1;
  localparam logic [1:0] SH_ASR = 2'd2;
  localparam logic [1:0] SH_ROR = 2'd3;

  localparam logic [5:0] STEP_AMT = 6'(STEP);

  logic [1:0]  state;
  logic [1:0]  kind;
  logic [5:0]  rem;
  logic [31:0] data;
  logic        carry;

  logic [31:0] dec_data;
  logic        dec_carry;
  logic [5:0]  dec_rem;
  logic [1:0]  dec_kind;
  logic [7:0]  amt_n;
  logic [5:0]  amt;
  logic [32:0] step_res;
  logic        unused_rs_hi;

  assign unused_rs_hi = ^val_rs[31:8];

  // One shifter step by s positions; returns {carry, data}. s == 0 passes through.
  function automatic logic [32:0] shift_step(input logic [1:0] k, input logic [31:0] d,
                                             input logic c, input logic [5:0] s);
    logic        [32:0] t;
    logic signed [32:0] sx;
    logic        [31:0] r;
    logic        [32:0] res;
    res = {c, d};
    if (s != 6'd0) begin
      case (k)
        SH_LSL: res = {1'b0, d} << s;
        SH_LSR: begin
          t   = {d, 1'b0} >> s;
          res = {t[0], t[32:1]};
        end
        SH_ASR: begin
          sx  = {d, 1'b0};
          t   = sx >>> s;
          res = {t[0], t[32:1]};
        end
        default: begin
          r   = (d >> s) | (d << (6'd32 - s));
          res = {r[31], r};
        end
      endcase
    end
    return res;
  endfunction

  // Resolved forms load their final value with a zero count; the others load the shift count.
  always_comb begin
    dec_data  = val_rm;
    dec_carry = carry_in;
    dec_rem   = 6'd0;
    dec_kind  = shift_operand[6:5];
    amt_n     = reg_shift ? val_rs[7:0] : {3'd0, shift_operand[11:7]};
    if (mem_R_en | mem_W_en) begin
      dec_data = {20'd0, shift_operand};
    end else if (imm) begin
      dec_data = {24'd0, shift_operand[7:0]};
      dec_kind = SH_ROR;
      dec_rem  = {1'b0, shift_operand[11:8], 1'b0};
    end else if (amt_n == 8'd0) begin
      if (!reg_shift) begin
        case (shift_operand[6:5])
          SH_LSR, SH_ASR: dec_rem = 6'd32;
          SH_ROR: begin
            dec_data  = {carry_in, val_rm[31:1]};
            dec_carry = val_rm[0];
          end
          default: ;
        endcase
      end
    end else begin
      case (shift_operand[6:5])
        SH_LSL, SH_LSR: dec_rem = (amt_n > 8'd33) ? 6'd33 : amt_n[5:0];
        SH_ASR:         dec_rem = (amt_n > 8'd32) ? 6'd32 : amt_n[5:0];
        default: begin
          if (amt_n[4:0] == 5'd0) dec_carry = val_rm[31];
          else                    dec_rem   = {1'b0, amt_n[4:0]};
        end
      endcase
    end
  end

  assign amt       = (rem < STEP_AMT) ? rem : STEP_AMT;
  assign step_res  = shift_step(kind, data, carry, amt);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      kind      <= SH_LSL;
      rem       <= 6'd0;
      val2      <= 32'd0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          state <= SHIFT;
          rem   <= dec_rem;
          kind  <= dec_kind;
        end
        SHIFT: begin
          rem <= rem - amt;
          if (rem == amt) begin
            state     <= DONE;
            val2      <= step_res[31:0];
            carry_out <= step_res[32];
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      data  <= dec_data;
      carry <= dec_carry;
    end else if (state == SHIFT) begin
      data  <= step_res[31:0];
      carry <= step_res[32];
    end
  end

`ifdef SHIFTER_BUSY_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 busy_cycles <= '0;
    else if (state == SHIFT) busy_cycles <= busy_cycles + CNT_W'(1);
  end
`endif

endmodule
